// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
package reg_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    // Index width that stays at least one bit wide even for a single requester.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int            cand;
    logic [IW-1:0] cand_idx;

    // Walk ptr, ptr+1, ... with an explicit wrap so NREQ need not be a power of two.
    always_comb begin
        onehot   = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IW'(cand);
            if (!any && req[cand_idx]) begin
                any              = 1'b1;
                idx              = cand_idx;
                onehot[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one storage register among NREQ writers, with bounded lock-based ownership.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ-1:0]             lock,
    input  logic [NREQ*WIDTH-1:0]       wdata,
    output logic [NREQ-1:0]             gnt,
    output logic [WIDTH-1:0]            q,
    output logic                        q_valid,
    output logic [idx_w(NREQ)-1:0]      owner
);

    localparam int IW = idx_w(NREQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam bit LOCK_EN = (MAX_HOLD > 1);

    state_t          state, state_nx;
    logic [IW-1:0]   ptr, ptr_nx;
    logic [HW-1:0]   hold_cnt, hold_nx, hold_inc;
    logic [IW-1:0]   owner_nx;
    logic            wr_en;
    logic [IW-1:0]   wr_idx;

    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign hold_inc = hold_cnt + HW'(1);

    always_comb begin
        gnt      = '0;
        state_nx = state;
        ptr_nx   = ptr;
        hold_nx  = hold_cnt;
        owner_nx = owner;
        wr_en    = 1'b0;
        wr_idx   = owner;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    gnt      = pick_onehot;
                    wr_en    = 1'b1;
                    wr_idx   = pick_idx;
                    owner_nx = pick_idx;
                    if (LOCK_EN && lock[pick_idx]) begin
                        state_nx = OWNED;
                        hold_nx  = HW'(1);
                    end else begin
                        ptr_nx = next_idx(pick_idx);
                    end
                end
            end
            OWNED: begin
                // A lapsed owner request costs one bubble cycle before arbitration resumes.
                if (req[owner]) begin
                    gnt[owner] = 1'b1;
                    wr_en      = 1'b1;
                    wr_idx     = owner;
                    hold_nx    = hold_inc;
                    if (!lock[owner] || hold_inc == HW'(MAX_HOLD)) begin
                        state_nx = IDLE;
                        ptr_nx   = next_idx(owner);
                        hold_nx  = '0;
                    end
                end else begin
                    state_nx = IDLE;
                    ptr_nx   = next_idx(owner);
                    hold_nx  = '0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (!rst_n) begin
            gnt   = '0;
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            owner    <= '0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            hold_cnt <= hold_nx;
            owner    <= owner_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (wr_en) begin
            q       <= wdata[wr_idx*WIDTH +: WIDTH];
            q_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed table-driven bench for reg_write_arbiter (NREQ=4, WIDTH=8, MAX_HOLD=3).
module tb_reg_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        q_valid;
    logic [1:0]  owner;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [31:0] wdata;
        logic [3:0]  exp_gnt;
        logic [7:0]  exp_q;
        logic        exp_qv;
        logic [1:0]  exp_owner;
    } vec_t;

    vec_t vecs[16];

    reg_write_arbiter #(
        .NREQ     (4),
        .WIDTH    (8),
        .MAX_HOLD (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .lock    (lock),
        .wdata   (wdata),
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid),
        .owner   (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l, input logic [31:0] d);
        req   = r;
        lock  = l;
        wdata = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    initial begin
        // req, lock, wdata, gnt, q after edge, q_valid, owner
        vecs[0]  = '{4'b0000, 4'b0000, 32'h13121110, 4'b0000, 8'h00, 1'b0, 2'd0};
        vecs[1]  = '{4'b1111, 4'b0000, 32'h13121110, 4'b0001, 8'h10, 1'b1, 2'd0};
        vecs[2]  = '{4'b1111, 4'b0000, 32'h13121110, 4'b0010, 8'h11, 1'b1, 2'd1};
        vecs[3]  = '{4'b1111, 4'b0000, 32'h13121110, 4'b0100, 8'h12, 1'b1, 2'd2};
        vecs[4]  = '{4'b1111, 4'b0000, 32'h13121110, 4'b1000, 8'h13, 1'b1, 2'd3};
        vecs[5]  = '{4'b1111, 4'b0000, 32'h13121110, 4'b0001, 8'h10, 1'b1, 2'd0};
        vecs[6]  = '{4'b0110, 4'b0010, 32'h23222120, 4'b0010, 8'h21, 1'b1, 2'd1};
        vecs[7]  = '{4'b0110, 4'b0010, 32'h23222120, 4'b0010, 8'h21, 1'b1, 2'd1};
        vecs[8]  = '{4'b0110, 4'b0010, 32'h23222120, 4'b0010, 8'h21, 1'b1, 2'd1};
        vecs[9]  = '{4'b0110, 4'b0010, 32'h23222120, 4'b0100, 8'h22, 1'b1, 2'd2};
        vecs[10] = '{4'b0110, 4'b0010, 32'h33323130, 4'b0010, 8'h31, 1'b1, 2'd1};
        vecs[11] = '{4'b1111, 4'b0010, 32'h33323130, 4'b0010, 8'h31, 1'b1, 2'd1};
        vecs[12] = '{4'b0100, 4'b0000, 32'h33323130, 4'b0000, 8'h31, 1'b1, 2'd1};
        vecs[13] = '{4'b0100, 4'b0000, 32'h33323130, 4'b0100, 8'h32, 1'b1, 2'd2};
        vecs[14] = '{4'b1000, 4'b0000, 32'hA5000000, 4'b1000, 8'hA5, 1'b1, 2'd3};
        vecs[15] = '{4'b0000, 4'b0000, 32'h00000000, 4'b0000, 8'hA5, 1'b1, 2'd3};

        rst_n = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 32'h0);
        #1;
        checkOutput("reset_q", 32'(q), 32'h00);
        checkOutput("reset_qv", 32'(q_valid), 32'h0);
        checkOutput("reset_gnt", 32'(gnt), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].req, vecs[i].lock, vecs[i].wdata);
            #1;
            checkOutput($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
            checkOutput($sformatf("v%0d_qv", i), 32'(q_valid), 32'(vecs[i].exp_qv));
            checkOutput($sformatf("v%0d_owner", i), 32'(owner), 32'(vecs[i].exp_owner));
            @(negedge clk);
        end

        // Take ownership by requester 2, then pull reset mid-burst between edges.
        applyStimulus(4'b1100, 4'b0100, 32'h44434241);
        #1;
        checkOutput("burst_gnt", 32'(gnt), 32'h4);
        @(posedge clk);
        #1;
        checkOutput("burst_q", 32'(q), 32'h43);
        checkOutput("burst_owner", 32'(owner), 32'd2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_q", 32'(q), 32'h00);
        checkOutput("midrst_qv", 32'(q_valid), 32'h0);
        checkOutput("midrst_gnt", 32'(gnt), 32'h0);
        checkOutput("midrst_owner", 32'(owner), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b1111, 4'b0000, 32'h44434241);
        #1;
        checkOutput("postrst_gnt", 32'(gnt), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("postrst_q", 32'(q), 32'h41);
        checkOutput("postrst_owner", 32'(owner), 32'd0);
        @(negedge clk);
        applyStimulus(4'b0000, 4'b0000, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
